// File: rtl/regfile_np_pkg.sv
// rtl/regfile_np_pkg.sv - shared types, constants and helpers for the regfile_np register file
package regfile_np_pkg;

  localparam int RF_MAX_W = 64;

  localparam logic ID_INC = 1'b0;
  localparam logic ID_DEC = 1'b1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } rf_flags_t;

  // Callers zero-extend to RF_MAX_W and truncate the result back to their width.
  function automatic logic [RF_MAX_W-1:0] rf_merge(
    input logic [RF_MAX_W-1:0] old_val,
    input logic [RF_MAX_W-1:0] data,
    input logic [RF_MAX_W-1:0] mask
  );
    return (old_val & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/regfile_np_incdec.sv
// rtl/regfile_np_incdec.sv - combinational +1/-1 with carry/borrow out
module regfile_np_incdec
  import regfile_np_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    if (i_dec == ID_DEC) begin
      o_result = i_value - WIDTH'(1);
      o_carry  = (i_value == '0);
    end else begin
      {o_carry, o_result} = {1'b0, i_value} + (WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/regfile_np.sv
// rtl/regfile_np.sv - flop-based multi-read register file with masked write, bypass and inc/dec
module regfile_np
  import regfile_np_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [WIDTH-1:0]       wmask,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  input  logic                   id_en,
  input  logic [AW-1:0]          id_addr,
  input  logic                   id_dec,
  output logic                   flag_valid,
  output logic                   flag_n,
  output logic                   flag_z,
  output logic                   flag_c,
  output logic                   collision
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  rf_flags_t        r_flags;
  logic             r_flag_valid;
  logic             r_collision;

  logic             w_wr_ok;
  logic             w_id_ok;
  logic             w_coll;
  logic             w_id_do;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_id_old;
  logic [WIDTH-1:0] w_id_res;
  logic             w_id_carry;

  // Out-of-range targets are treated as if the request never happened.
  assign w_wr_ok  = we    && ({1'b0, waddr}   < DEPTH_W);
  assign w_id_ok  = id_en && ({1'b0, id_addr} < DEPTH_W);
  assign w_coll   = w_wr_ok && w_id_ok && (waddr == id_addr);
  assign w_id_do  = w_id_ok && !w_coll;

  assign w_wr_old = w_wr_ok ? r_mem[waddr]   : '0;
  assign w_id_old = w_id_ok ? r_mem[id_addr] : '0;
  assign w_merged = WIDTH'(rf_merge(RF_MAX_W'(w_wr_old), RF_MAX_W'(wdata), RF_MAX_W'(wmask)));

  regfile_np_incdec #(.WIDTH(WIDTH)) u_incdec (
    .i_value  (w_id_old),
    .i_dec    (id_dec),
    .o_result (w_id_res),
    .o_carry  (w_id_carry)
  );

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_rd;

    assign w_ra = raddr[gi*AW +: AW];

    always_comb begin
      w_rd = '0;
      if ({1'b0, w_ra} < DEPTH_W) begin
        if ((BYPASS != 0) && w_wr_ok && (w_ra == waddr)) begin
          w_rd = w_merged;
        end else begin
          w_rd = r_mem[w_ra];
        end
      end
    end

    assign rdata[gi*WIDTH +: WIDTH] = w_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_flags      <= '0;
      r_flag_valid <= 1'b0;
      r_collision  <= 1'b0;
    end else begin
      r_flag_valid <= w_wr_ok || w_id_do;
      r_collision  <= w_coll;
      if (w_wr_ok) begin
        r_mem[waddr] <= w_merged;
      end
      if (w_id_do) begin
        r_mem[id_addr] <= w_id_res;
      end
      // Inc/dec owns the flags when it runs; a plain write keeps the old carry.
      if (w_id_do) begin
        r_flags.n <= w_id_res[WIDTH-1];
        r_flags.z <= (w_id_res == '0);
        r_flags.c <= w_id_carry;
      end else if (w_wr_ok) begin
        r_flags.n <= w_merged[WIDTH-1];
        r_flags.z <= (w_merged == '0);
      end
    end
  end

  assign flag_valid = r_flag_valid;
  assign flag_n     = r_flags.n;
  assign flag_z     = r_flags.z;
  assign flag_c     = r_flags.c;
  assign collision  = r_collision;

endmodule

// File: tb/tb_regfile_np.sv
// tb/tb_regfile_np.sv - bench for regfile_np (DEPTH=4 BYPASS=1 and DEPTH=3 BYPASS=0 instances)
module tb_regfile_np;

  logic       clk;
  logic       reset;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [7:0] wmask;
  logic [3:0] raddr;
  logic       id_en;
  logic [1:0] id_addr;
  logic       id_dec;

  logic [15:0] a_rdata, b_rdata;
  logic a_fv, a_fn, a_fz, a_fc, a_col;
  logic b_fv, b_fn, b_fz, b_fc, b_col;

  int nvec = 0;
  int nmis = 0;

  int   mem  [2][4];
  logic fv   [2];
  logic fn   [2];
  logic fz   [2];
  logic fc   [2];
  logic fcol [2];
  int   dep  [2] = '{4, 3};
  int   byp  [2] = '{1, 0};

  regfile_np #(.WIDTH(8), .DEPTH(4), .NREAD(2), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr(raddr), .rdata(a_rdata), .id_en(id_en), .id_addr(id_addr), .id_dec(id_dec),
    .flag_valid(a_fv), .flag_n(a_fn), .flag_z(a_fz), .flag_c(a_fc), .collision(a_col)
  );

  regfile_np #(.WIDTH(8), .DEPTH(3), .NREAD(2), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr(raddr), .rdata(b_rdata), .id_en(id_en), .id_addr(id_addr), .id_dec(id_dec),
    .flag_valid(b_fv), .flag_n(b_fn), .flag_z(b_fz), .flag_c(b_fc), .collision(b_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: registers as plain integers, updated once per clock edge.
  task automatic model_step();
    int wr, idok, col, iddo, old_v, mg, iv, ir, cy;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int k = 0; k < 4; k++) mem[d][k] = 0;
        fv[d] = 0; fn[d] = 0; fz[d] = 0; fc[d] = 0; fcol[d] = 0;
      end else begin
        wr    = (we && waddr < dep[d]) ? 1 : 0;
        idok  = (id_en && id_addr < dep[d]) ? 1 : 0;
        col   = (wr && idok && waddr == id_addr) ? 1 : 0;
        iddo  = (idok && !col) ? 1 : 0;
        old_v = wr ? mem[d][waddr] : 0;
        mg    = (old_v & (~int'(wmask) & 255)) | (int'(wdata) & int'(wmask));
        iv    = idok ? mem[d][id_addr] : 0;
        if (!id_dec) begin ir = (iv + 1) % 256;   cy = (iv == 255); end
        else         begin ir = (iv + 255) % 256; cy = (iv == 0);   end
        fv[d]   = (wr || iddo);
        fcol[d] = col[0];
        if (iddo) begin
          fn[d] = (ir >= 128); fz[d] = (ir == 0); fc[d] = cy[0];
        end else if (wr) begin
          fn[d] = (mg >= 128); fz[d] = (mg == 0);
        end
        if (wr)   mem[d][waddr]   = mg;
        if (iddo) mem[d][id_addr] = ir;
      end
    end
  endtask

  function automatic int exp_rd(int d, int a);
    int mg;
    if (a >= dep[d]) return 0;
    if (byp[d] != 0 && we && waddr == a) begin
      mg = (mem[d][a] & (~int'(wmask) & 255)) | (int'(wdata) & int'(wmask));
      return mg;
    end
    return mem[d][a];
  endfunction

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [7:0] wmk, input logic ie, input logic [1:0] ia,
                       input logic idd);
    we = w; waddr = wa; wdata = wd; wmask = wmk;
    id_en = ie; id_addr = ia; id_dec = idd;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a0, input logic [1:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'd1, 8'hA5, 8'hFF, 1'b0, 2'd0, 1'b0);
    clk_step();
    nvec++;
    if (a_fv !== 1'b1 || a_fn !== 1'b1) begin
      nmis++; $display("FAIL pre_reset_flags got v=%b n=%b want v=1 n=1", a_fv, a_fn);
    end
    idle();
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    nvec++;
    if (a_fv !== 1'b0 || a_col !== 1'b0 || b_fv !== 1'b0 || b_col !== 1'b0) begin
      nmis++; $display("FAIL reset_flags got a_v=%b a_col=%b b_v=%b b_col=%b want 0", a_fv, a_col, b_fv, b_col);
    end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 2'(i));
      nvec++;
      if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
        nmis++; $display("FAIL reset_read addr=%0d got a=%h b=%h want 0000", i, a_rdata, b_rdata);
      end
    end
  endtask

  task automatic test_masked_write();
    drive(1'b1, 2'd2, 8'hFF, 8'hFF, 1'b0, 2'd0, 1'b0);
    clk_step();
    drive(1'b1, 2'd2, 8'h00, 8'h0F, 1'b0, 2'd0, 1'b0);
    clk_step();
    nvec++;
    if (a_fv !== 1'b1 || a_fn !== 1'b1 || a_fz !== 1'b0) begin
      nmis++; $display("FAIL masked_flags got v=%b n=%b z=%b want 1 1 0", a_fv, a_fn, a_fz);
    end
    idle();
    rd(2'd2, 2'd2);
    nvec++;
    if (a_rdata !== 16'hF0F0 || b_rdata !== 16'hF0F0) begin
      nmis++; $display("FAIL masked_value got a=%h b=%h want f0f0", a_rdata, b_rdata);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 2'd3, 8'h3C, 8'hFF, 1'b0, 2'd0, 1'b0);
    rd(2'd3, 2'd0);
    nvec++;
    if (a_rdata[7:0] !== 8'h3C) begin
      nmis++; $display("FAIL bypass_r3 got %h want 3c", a_rdata[7:0]);
    end
    clk_step();
    drive(1'b1, 2'd1, 8'h3C, 8'hFF, 1'b0, 2'd0, 1'b0);
    rd(2'd1, 2'd1);
    nvec++;
    if (a_rdata !== 16'h3C3C || b_rdata !== 16'h0000) begin
      nmis++; $display("FAIL bypass_r1 got a=%h b=%h want a=3c3c b=0000", a_rdata, b_rdata);
    end
    clk_step();
    idle();
    rd(2'd1, 2'd3);
    nvec++;
    if (b_rdata !== 16'h003C || a_rdata !== 16'h3C3C) begin
      nmis++; $display("FAIL bypass_after got a=%h b=%h want a=3c3c b=003c", a_rdata, b_rdata);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 2'd0, 1'b0);
    clk_step();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0);
    rd(2'd0, 2'd0);
    nvec++;
    if (a_rdata[7:0] !== 8'hFF) begin
      nmis++; $display("FAIL wrap_no_bypass got %h want ff", a_rdata[7:0]);
    end
    clk_step();
    nvec++;
    if (a_fv !== 1'b1 || a_fz !== 1'b1 || a_fc !== 1'b1 || a_fn !== 1'b0 || b_fc !== 1'b1) begin
      nmis++; $display("FAIL wrap_inc_flags got v=%b n=%b z=%b c=%b b_c=%b want 1 0 1 1 1", a_fv, a_fn, a_fz, a_fc, b_fc);
    end
    rd(2'd0, 2'd0);
    nvec++;
    if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
      nmis++; $display("FAIL wrap_inc_value got a=%h b=%h want 0000", a_rdata, b_rdata);
    end
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 2'd0, 1'b1);
    clk_step();
    nvec++;
    if (a_fn !== 1'b1 || a_fc !== 1'b1 || a_fz !== 1'b0) begin
      nmis++; $display("FAIL wrap_dec_flags got n=%b z=%b c=%b want 1 0 1", a_fn, a_fz, a_fc);
    end
    idle();
    rd(2'd0, 2'd0);
    nvec++;
    if (a_rdata !== 16'hFFFF || b_rdata !== 16'hFFFF) begin
      nmis++; $display("FAIL wrap_dec_value got a=%h b=%h want ffff", a_rdata, b_rdata);
    end
    drive(1'b1, 2'd1, 8'h01, 8'hFF, 1'b0, 2'd0, 1'b0);
    clk_step();
    nvec++;
    if (a_fc !== 1'b1 || a_fn !== 1'b0 || a_fz !== 1'b0) begin
      nmis++; $display("FAIL write_holds_c got n=%b z=%b c=%b want 0 0 1", a_fn, a_fz, a_fc);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 2'd1, 8'h10, 8'hFF, 1'b0, 2'd0, 1'b0);
    clk_step();
    drive(1'b1, 2'd1, 8'h20, 8'hFF, 1'b1, 2'd1, 1'b0);
    clk_step();
    nvec++;
    if (a_col !== 1'b1 || a_fv !== 1'b1 || a_fn !== 1'b0 || a_fz !== 1'b0) begin
      nmis++; $display("FAIL coll_same got col=%b v=%b n=%b z=%b want 1 1 0 0", a_col, a_fv, a_fn, a_fz);
    end
    drive(1'b1, 2'd2, 8'h7F, 8'hFF, 1'b0, 2'd0, 1'b0);
    rd(2'd1, 2'd1);
    nvec++;
    if (a_rdata[7:0] !== 8'h20) begin
      nmis++; $display("FAIL coll_same_value got %h want 20", a_rdata[7:0]);
    end
    clk_step();
    nvec++;
    if (a_col !== 1'b0) begin
      nmis++; $display("FAIL coll_pulse got %b want 0", a_col);
    end
    drive(1'b1, 2'd1, 8'h55, 8'hFF, 1'b1, 2'd2, 1'b0);
    clk_step();
    nvec++;
    if (a_col !== 1'b0 || a_fn !== 1'b1 || a_fz !== 1'b0 || a_fc !== 1'b0) begin
      nmis++; $display("FAIL coll_diff got col=%b n=%b z=%b c=%b want 0 1 0 0", a_col, a_fn, a_fz, a_fc);
    end
    idle();
    rd(2'd1, 2'd2);
    nvec++;
    if (a_rdata !== 16'h8055) begin
      nmis++; $display("FAIL coll_diff_value got %h want 8055", a_rdata);
    end
  endtask

  task automatic test_range();
    idle();
    clk_step();
    drive(1'b1, 2'd3, 8'h77, 8'hFF, 1'b0, 2'd0, 1'b0);
    clk_step();
    nvec++;
    if (b_fv !== 1'b0 || b_col !== 1'b0) begin
      nmis++; $display("FAIL range_write got v=%b col=%b want 0 0", b_fv, b_col);
    end
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 2'd3, 1'b0);
    clk_step();
    nvec++;
    if (b_fv !== 1'b0 || b_col !== 1'b0) begin
      nmis++; $display("FAIL range_incdec got v=%b col=%b want 0 0", b_fv, b_col);
    end
    idle();
    rd(2'd3, 2'd3);
    nvec++;
    if (b_rdata !== 16'h0000 || a_rdata !== 16'h7878) begin
      nmis++; $display("FAIL range_read got b=%h a=%h want b=0000 a=7878", b_rdata, a_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), 2'(i));
      nvec++;
      if (b_rdata[7:0] !== 8'(mem[1][i])) begin
        nmis++; $display("FAIL range_keep addr=%0d got %h want %h", i, b_rdata[7:0], 8'(mem[1][i]));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        id_addr = waddr;
        wdata   = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      end
      rd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int p = 0; p < 2; p++) begin
        nvec++;
        if (a_rdata[p*8 +: 8] !== 8'(exp_rd(0, int'(raddr[p*2 +: 2])))) begin
          nmis++; $display("FAIL rand_read_a n=%0d port=%0d got %h want %h", n, p, a_rdata[p*8 +: 8], 8'(exp_rd(0, int'(raddr[p*2 +: 2]))));
        end
        nvec++;
        if (b_rdata[p*8 +: 8] !== 8'(exp_rd(1, int'(raddr[p*2 +: 2])))) begin
          nmis++; $display("FAIL rand_read_b n=%0d port=%0d got %h want %h", n, p, b_rdata[p*8 +: 8], 8'(exp_rd(1, int'(raddr[p*2 +: 2]))));
        end
      end
      clk_step();
      nvec++;
      if ({a_fv, a_fn, a_fz, a_fc, a_col} !== {fv[0], fn[0], fz[0], fc[0], fcol[0]}) begin
        nmis++; $display("FAIL rand_flags_a n=%0d got %b want %b", n, {a_fv, a_fn, a_fz, a_fc, a_col}, {fv[0], fn[0], fz[0], fc[0], fcol[0]});
      end
      nvec++;
      if ({b_fv, b_fn, b_fz, b_fc, b_col} !== {fv[1], fn[1], fz[1], fc[1], fcol[1]}) begin
        nmis++; $display("FAIL rand_flags_b n=%0d got %b want %b", n, {b_fv, b_fn, b_fz, b_fc, b_col}, {fv[1], fn[1], fz[1], fc[1], fcol[1]});
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    raddr = 4'h0;
    idle();
    clk_step();
    clk_step();
    reset = 1'b0;
    test_reset();
    test_masked_write();
    test_bypass();
    test_wrap();
    test_collision();
    test_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/regfile_np.md
Name: regfile_np

Overview:
- Parametrised, flop-based register file for the hmc-6502 datapath. It replaces the fixed 4x8 latch-based file.
- Adds N read ports, a per-bit write mask, optional write-to-read bypass, and an in-place increment/decrement path for INX/DEX/INY/DEY/stack-pointer updates.
- Produces registered N/Z/C flag results, which the control unit folds into P.

Parameters:
WIDTH, 8, bits per register
DEPTH, 4, number of registers (need not be a power of two)
NREAD, 2, number of combinational read ports
BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads see the stored value only
AW (localparam), $clog2(DEPTH) (min 1), address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
we  in  1  write enable
waddr  in  AW  write address
wdata  in  WIDTH  write data
wmask  in  WIDTH  per-bit write enable; a bit is written only where wmask=1
raddr  in  NREAD*AW  packed read addresses, port i = raddr[i*AW +: AW]
rdata  out  NREAD*WIDTH  packed read data, port i = rdata[i*WIDTH +: WIDTH]
id_en  in  1  in-place inc/dec request
id_addr  in  AW  inc/dec target register
id_dec  in  1  0 = +1, 1 = -1
flag_valid  out  1  pulses one cycle after a flag-producing update
flag_n  out  1  MSB of last updated value
flag_z  out  1  last updated value == 0
flag_c  out  1  inc/dec wrap (carry out of inc / borrow out of dec)
collision  out  1  one-cycle pulse: id_en dropped because of a write conflict

Behaviour:
- Reset
  - All registers cleared to 0.
  - flag_valid, flag_n, flag_z, flag_c and collision are all 0.
  - Reset overrides we/id_en in the same cycle; a request in flight during reset is discarded.
- Write
  - On posedge clk with we=1: reg[waddr] <= (reg & ~wmask) | (wdata & wmask).
  - wmask=0 leaves the register unchanged but still updates the flags from the merged value.
- Inc/dec
  - On posedge with id_en=1 (and no conflict): reg[id_addr] <= reg ± 1, modulo 2^WIDTH.
  - flag_c=1 on inc of all-ones→0 and on dec of 0→all-ones; otherwise flag_c=0.
- Flags
  - Registered; they reflect the value written at edge k and are valid while flag_valid=1 in cycle k+1.
  - On a write, flag_c holds its previous value. flag_n = result[WIDTH-1]; flag_z = (result==0).
  - flag_valid=0 in any cycle not preceded by an accepted write or inc/dec; N/Z/C hold their last values.
- Write and inc/dec in the same cycle
  - Different addresses: both are performed. Flags come from the inc/dec result; C from inc/dec.
  - Same address: the write wins and the inc/dec is dropped. collision=1 in the next cycle; flags come from the write.
- Read
  - Combinational, zero latency.
  - BYPASS=1: if we=1 and raddr==waddr, rdata = the merged write value; otherwise the stored value.
  - Inc/dec results are never bypassed; they are visible the cycle after the edge.
  - BYPASS=0: always the stored value.
- Out-of-range addresses (>= DEPTH)
  - Writes and inc/dec are ignored: no flags, no collision.
  - Reads return 0.
- Ports behave independently; any number of ports may read the same address.

Decomposition:
- Package regfile_np_pkg holds:
  - typedef rf_flags_t (packed struct n,z,c)
  - localparam ID_INC=1'b0, ID_DEC=1'b1
  - function rf_merge(old,data,mask)
- Sub-module regfile_np_incdec (WIDTH):
  - Combinational ±1 with wrap/carry output.
  - Instantiated once and driven by the selected register.

Test Plan:
- Reset:
  - Write 8'hA5 to r1, assert reset for one cycle → all rdata=0.
  - flag_valid=0, collision=0 after reset.
- Masked write:
  - r2=8'hFF; write wdata=8'h00, wmask=8'h0F → r2=8'hF0.
  - Next cycle flag_valid=1, flag_n=1, flag_z=0.
- Bypass:
  - BYPASS=1, write r3=8'h3C, port0 raddr=3 in the same cycle → rdata0=8'h3C before the edge.
  - BYPASS=0 build → rdata0 = old value (0).
- Wrap:
  - r0=8'hFF, id_en inc → r0=8'h00, flag_z=1, flag_c=1.
  - Then dec → r0=8'hFF, flag_n=1, flag_c=1, flag_z=0.
- Collision:
  - r1=8'h10, we to r1 with 8'h20 plus id_en inc r1 in the same cycle → r1=8'h20, collision=1 one cycle later.
  - Different addresses (write r1, inc r2=8'h7F) → r1 written, r2=8'h80, flag_n=1, collision=0.
- Range:
  - DEPTH=3: write/inc addr 3 → no state change, flag_valid=0, read addr 3 → 0.
